// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator with a shared prescaler, a shared period counter
// and per-channel duty compare. New period/duty values are double-buffered in
// shadow registers and adopted only at a period boundary.
// Optional build macro: PWM_CENTER_ALIGN_EN selects up/down (center-aligned)
// counting instead of the default edge-aligned sawtooth.
module pwm_multi_ch #(
  parameter int unsigned CH_NUM  = 4,
  parameter int unsigned RES_W   = 8,
  parameter int unsigned PRE_DIV = 10000
) (
  input  logic                      I_clk,
  input  logic                      I_rst_n,
  input  logic                      I_en,
  input  logic [RES_W-1:0]          I_period,
  input  logic [CH_NUM*RES_W-1:0]   I_duty,
  input  logic [CH_NUM-1:0]         I_ch_en,
  input  logic                      I_load,
  output logic [CH_NUM-1:0]         O_PWM,
  output logic                      O_period_end
);

  localparam int unsigned PS_W = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state;
  logic [PS_W-1:0]           ps;
  logic [RES_W-1:0]          cnt;
  logic [RES_W-1:0]          period_sh;
  logic [CH_NUM*RES_W-1:0]   duty_sh;
  logic                      pend;

  logic                      tick;
  logic                      wrap;
  logic [RES_W-1:0]          cnt_nxt;
  logic [CH_NUM-1:0]         hi;

`ifdef PWM_CENTER_ALIGN_EN
  logic                      down;
  logic                      down_nxt;

  // Up/down counter step: 0..period then back down; the boundary is the
  // step from 1 to 0, so a full period spans 2*period ticks.
  always_comb begin
    tick     = (ps == PS_W'(PRE_DIV - 1));
    wrap     = 1'b0;
    down_nxt = down;
    cnt_nxt  = cnt;
    if (!down) begin
      if (cnt >= period_sh) begin
        if (period_sh == '0) begin
          wrap = 1'b1;
        end else begin
          down_nxt = 1'b1;
          cnt_nxt  = cnt - RES_W'(1);
        end
      end else begin
        cnt_nxt = cnt + RES_W'(1);
      end
    end else if (cnt <= RES_W'(1)) begin
      wrap     = 1'b1;
      down_nxt = 1'b0;
      cnt_nxt  = '0;
    end else begin
      cnt_nxt = cnt - RES_W'(1);
    end
    wrap = wrap & tick;
  end

  // Duty compare; the down slope uses <= so the high window is symmetric
  // about the count-0 turnaround and lasts 2*duty ticks.
  always_comb begin
    hi = '0;
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      if (down) hi[k] = (cnt <= duty_sh[k*RES_W +: RES_W]);
      else      hi[k] = (cnt <  duty_sh[k*RES_W +: RES_W]);
    end
  end
`else
  // Edge-aligned sawtooth step: 0..period, then wrap to 0.
  always_comb begin
    tick    = (ps == PS_W'(PRE_DIV - 1));
    wrap    = tick && (cnt >= period_sh);
    cnt_nxt = wrap ? '0 : cnt + RES_W'(1);
  end

  // Duty compare against the current counter value.
  always_comb begin
    hi = '0;
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      hi[k] = (cnt < duty_sh[k*RES_W +: RES_W]);
    end
  end
`endif

  // IDLE/RUN state machine with prescaler, counter, shadow load and
  // registered outputs.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state        <= IDLE;
      ps           <= '0;
      cnt          <= '0;
      period_sh    <= '0;
      duty_sh      <= '0;
      pend         <= 1'b0;
      O_PWM        <= '0;
      O_period_end <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      down         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ps           <= '0;
          cnt          <= '0;
          pend         <= 1'b0;
          O_PWM        <= '0;
          O_period_end <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
          down         <= 1'b0;
`endif
          if (I_en) begin
            state     <= RUN;
            period_sh <= I_period;
            duty_sh   <= I_duty;
          end
        end
        RUN: begin
          if (!I_en) begin
            state        <= IDLE;
            ps           <= '0;
            cnt          <= '0;
            pend         <= 1'b0;
            O_PWM        <= '0;
            O_period_end <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            down         <= 1'b0;
`endif
          end else begin
            O_PWM        <= hi & I_ch_en;
            O_period_end <= wrap;
            ps           <= tick ? '0 : ps + PS_W'(1);
            if (tick) begin
              cnt  <= cnt_nxt;
`ifdef PWM_CENTER_ALIGN_EN
              down <= down_nxt;
`endif
            end
            // A load request arriving on the wrap tick itself is honoured
            // immediately rather than deferred a whole period.
            if (wrap) begin
              if (pend || I_load) begin
                period_sh <= I_period;
                duty_sh   <= I_duty;
              end
              pend <= 1'b0;
            end else if (I_load) begin
              pend <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed testbench for pwm_multi_ch (PRE_DIV=1, RES_W=8, CH_NUM=4).
module tb_pwm_multi_ch;
  localparam int CH = 4;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic            load;
  logic [W-1:0]    period;
  logic [CH*W-1:0] duty;
  logic [CH-1:0]   ch_en;
  logic [CH-1:0]   pwm;
  logic            pe;

  int vectors     = 0;
  int miscompares = 0;
  int c0, c1, c2, c3, npe, first_pe, acc;
  logic [15:0] pat, pepat;

  always #5 clk = ~clk;

  pwm_multi_ch #(.CH_NUM(CH), .RES_W(W), .PRE_DIV(1)) dut (
    .I_clk       (clk),
    .I_rst_n     (rst_n),
    .I_en        (en),
    .I_period    (period),
    .I_duty      (duty),
    .I_ch_en     (ch_en),
    .I_load      (load),
    .O_PWM       (pwm),
    .O_period_end(pe)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Run n cycles, sampling on the falling edge and tallying highs per channel.
  task automatic run(input int n);
    c0 = 0; c1 = 0; c2 = 0; c3 = 0; npe = 0; first_pe = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      c0 += int'(pwm[0]); c1 += int'(pwm[1]);
      c2 += int'(pwm[2]); c3 += int'(pwm[3]);
      if (pe === 1'b1) begin
        npe++;
        if (first_pe == 0) first_pe = i;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0;
    period = '0; duty = '0; ch_en = '0;
    repeat (2) @(negedge clk);
    check("rst_pwm", 32'(pwm), 32'd0);
    check("rst_pe", 32'(pe), 32'd0);
    rst_n = 1'b1;
    run(3);
    check("idle_pwm", 32'(c0 + c1 + c2 + c3), 32'd0);
    check("idle_pe", 32'(npe), 32'd0);

`ifdef PWM_CENTER_ALIGN_EN
    period = 8'd4; duty = {8'd2, 8'd2, 8'd2, 8'd2}; ch_en = '1;
    en = 1'b1; @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pat[i]   = pwm[0];
      pepat[i] = pe;
    end
    check("ctr_pattern", 32'(pat), 32'h0000C3C3);
    check("ctr_pe_pattern", 32'(pepat), 32'h00008080);
    check("ctr_all_ch", 32'(pwm), 32'hF);
`else
    // Edge test
    period = 8'd9; duty = {8'd10, 8'd5, 8'd3, 8'd0}; ch_en = '1;
    en = 1'b1; @(negedge clk);
    run(20);
    check("edge_ch0", 32'(c0), 32'd0);
    check("edge_ch1", 32'(c1), 32'd6);
    check("edge_ch2", 32'(c2), 32'd10);
    check("edge_ch3", 32'(c3), 32'd20);
    check("edge_pe_cnt", 32'(npe), 32'd2);
    check("edge_pe_pos", 32'(first_pe), 32'd10);

    // Shadow test: load requested mid-period
    run(3); acc = c1;
    duty[15:8] = 8'd7; load = 1'b1;
    run(1); acc += c1;
    load = 1'b0;
    run(6); acc += c1;
    check("shadow_cur_ch1", 32'(acc), 32'd3);
    run(10);
    check("shadow_next_ch1", 32'(c1), 32'd7);
    check("shadow_next_ch2", 32'(c2), 32'd5);

    // Load test: duty change without load is ignored
    duty[15:8] = 8'd2;
    run(50);
    check("noload_ch1", 32'(c1), 32'd35);
    run(9); acc = c1;
    load = 1'b1;
    run(1); acc += c1;
    check("load_wrap_pe", 32'(npe), 32'd1);
    load = 1'b0;
    check("load_old_ch1", 32'(acc), 32'd7);
    run(10);
    check("load_new_ch1", 32'(c1), 32'd2);

    // Disable test
    run(2);
    check("dis_before", 32'(pwm), 32'hE);
    en = 1'b0;
    run(1);
    check("dis_after", 32'(pwm), 32'd0);
    run(4);
    check("dis_hold", 32'(c0 + c1 + c2 + c3), 32'd0);
    check("dis_pe", 32'(npe), 32'd0);
    period = 8'd4; duty = {8'd5, 8'd4, 8'd2, 8'd1};
    en = 1'b1; @(negedge clk);
    run(10);
    check("p4_ch0", 32'(c0), 32'd2);
    check("p4_ch1", 32'(c1), 32'd4);
    check("p4_ch2", 32'(c2), 32'd8);
    check("p4_ch3", 32'(c3), 32'd10);
    check("p4_pe_cnt", 32'(npe), 32'd2);
    check("p4_pe_pos", 32'(first_pe), 32'd5);

    // Channel enable acts without waiting for a boundary
    ch_en = 4'b0111;
    run(1);
    check("chen_off", 32'(pwm), 32'h7);
    ch_en = 4'b1111;
    run(1);
    check("chen_on", 32'(pwm), 32'hE);

    // Asynchronous reset mid-period
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pwm", 32'(pwm), 32'd0);
    check("async_rst_pe", 32'(pe), 32'd0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run(3);
    check("post_rst_idle", 32'(c0 + c1 + c2 + c3 + npe), 32'd0);
    en = 1'b1; @(negedge clk);
    run(1);
    check("post_rst_run", 32'(pwm), 32'hF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pwm_multi_ch.md
PWM_MULTI_CH -- requirements
Module: pwm_multi_ch

Interface
REQ-001 Parameter CH_NUM, default 4, number of independent PWM channels (1..16).
REQ-002 Parameter RES_W, default 8, width of period/duty counters.
REQ-003 Parameter PRE_DIV, default 10000, I_clk cycles per count tick (100 MHz / 10000 = 10 kHz tick).
REQ-004 I_clk  input  1  system clock, rising-edge.
REQ-005 I_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 I_en  input  1  global enable, active high.
REQ-007 I_period  input  RES_W  period length minus one, in ticks.
REQ-008 I_duty  input  CH_NUM*RES_W  per-channel high time in ticks; channel k at bits [k*RES_W +: RES_W].
REQ-009 I_ch_en  input  CH_NUM  per-channel output enable.
REQ-010 I_load  input  1  single-cycle request to adopt new I_period/I_duty at the next period boundary.
REQ-011 O_PWM  output  CH_NUM  registered PWM outputs.
REQ-012 O_period_end  output  1  one-cycle pulse on each period wrap.

Function
REQ-013 The block SHALL have two states: IDLE (I_en=0) and RUN (I_en=1).
REQ-014 IDLE SHALL hold the prescaler, period counter, load-pending flag and all outputs at 0.
REQ-015 On the IDLE->RUN transition, the block SHALL copy I_period and I_duty directly into shadow registers in the same cycle.
REQ-016 RUN->IDLE SHALL occur on the first cycle I_en=0, including mid-period; O_PWM SHALL be 0 from the next edge.
REQ-017 The prescaler SHALL count 0..PRE_DIV-1 and assert an internal tick at PRE_DIV-1, then wrap to 0; PRE_DIV=1 SHALL tick every cycle.
REQ-018 The period counter SHALL advance by one per tick and wrap from period_shadow to 0; period length SHALL be period_shadow+1 ticks.
REQ-019 O_PWM[k] SHALL be registered as (cnt < duty_shadow[k]) & I_ch_en[k], one cycle after the counter value.
REQ-020 duty_shadow=0 SHALL give constant 0; duty_shadow > period_shadow SHALL give constant 1 (no glitch at wrap).
REQ-021 I_load SHALL set a pending flag; on the wrap tick with the flag set, shadows SHALL take I_period/I_duty and the flag SHALL clear.
REQ-022 If I_load coincides with a wrap tick, the shadows SHALL load on that wrap.
REQ-023 Repeated I_load pulses before a wrap SHALL cause only one load, using the values present at the wrap.
REQ-024 Without a pending load, I_period/I_duty changes SHALL have no effect on the outputs.
REQ-025 O_period_end SHALL pulse for one cycle on each wrap tick in RUN, and SHALL never pulse in IDLE.
REQ-026 I_ch_en changes SHALL take effect one cycle later, without waiting for a boundary.

Reset
REQ-027 Assertion of I_rst_n=0 SHALL immediately clear the state to IDLE and clear the counters, shadows, pending flag, O_PWM and O_period_end, regardless of clock.
REQ-028 After reset release, the block SHALL stay in IDLE until I_en=1 is sampled.

Configuration
REQ-029 With macro PWM_CENTER_ALIGN_EN defined, the counter SHALL count up 0..period_shadow and then down to 0. The period SHALL be 2*period_shadow ticks, and O_period_end and the shadow load SHALL occur at the count-0 turnaround.
REQ-030 Without PWM_CENTER_ALIGN_EN, only the edge-aligned behaviour of REQ-018 SHALL be compiled; no up/down logic SHALL exist.

Verification (PRE_DIV=1, RES_W=8, CH_NUM=4)
REQ-031 Edge test: reset, period=9, duty={0,3,5,10}, all enabled, I_en=1. Required: ch0 always 0; ch1 high 3 of 10 cycles; ch2 high 5 of 10; ch3 always 1; O_period_end every 10 cycles.
REQ-032 Shadow test: mid-period, pulse I_load with duty ch1=7. Required: current period keeps 3 high; next period has 7 high; no runt pulse.
REQ-033 Load test: change I_duty without I_load. Required: outputs unchanged for 5 periods. Then assert I_load on the wrap cycle. Required: new duty in the immediately following period.
REQ-034 Disable test: drop I_en mid high phase. Required: all O_PWM=0 next cycle. Then raise I_en with period=4. Required: new period active from the first tick.
REQ-035 Reset test: assert I_rst_n low asynchronously mid-period. Required: all outputs 0 before the next clock edge; stays IDLE after release until I_en sampled 1.
REQ-036 Center test: with PWM_CENTER_ALIGN_EN, period=4, duty=2. Required: period 8 cycles; output symmetric, high 4 cycles centred on the turnaround at count 0.
